ex_matrix_unit: RTL and testbench



---
 rtl/ex_matrix_if.sv | 37 +++
 rtl/ex_matrix_unit.sv | 154 +++++++++++++++
 tb/tb_ex_matrix_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_matrix_if.sv
// Handshake/bus bundle between the ID/EX pipeline register and the
// execute-stage matrix coprocessor (ex_matrix_unit).
//
// Handshake: the pipeline presents an instruction by holding start=1 with
// func3/a_data/b_data/rd_in stable; the unit accepts it on the first edge
// where it is IDLE with start=1 (no flush). stall is the "not ready" signal:
// upstream stages hold while stall=1. done is a one-cycle valid pulse for
// result/res_rd, which then hold until the next accept.
interface ex_matrix_if #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 4
);
  localparam int DW = DIM * DIM * ELEM_W;

  logic          flush;
  logic          start;
  logic [2:0]    func3;
  logic [DW-1:0] a_data;
  logic [DW-1:0] b_data;
  logic [4:0]    rd_in;
  logic          stall;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;
  logic [4:0]    res_rd;
  logic [1:0]    state_dbg;

  modport master (
    output flush, start, func3, a_data, b_data, rd_in,
    input  stall, busy, done, result, res_rd, state_dbg
  );

  modport slave (
    input  flush, start, func3, a_data, b_data, rd_in,
    output stall, busy, done, result, res_rd, state_dbg
  );
endinterface

// File: rtl/ex_matrix_unit.sv
// Execute-stage matrix coprocessor. Element-wise ops (MADD, MSUB, MEMUL,
// MTRANS) complete at the accept edge; MATMUL computes one result row per
// cycle from latched operands. stall freezes IF/ID/EX while an instruction
// is being accepted or computed.
//
// Optional build macro MATRIX_SAT_EN: when defined, every op except MTRANS
// saturates its full-precision value to the signed element range instead of
// keeping the low ELEM_W bits.
module ex_matrix_unit #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 4
) (
  input logic          clk,
  input logic          rst,
  ex_matrix_if.slave   bus
);
  localparam int DW  = DIM * DIM * ELEM_W;
  localparam int RW  = (DIM > 1) ? $clog2(DIM) : 1;
  // Wide enough for a sum of DIM full-precision products.
  localparam int AW  = 2 * ELEM_W + $clog2(DIM);
  localparam int ROW_W = DIM * ELEM_W;

  localparam logic [2:0] OP_MADD   = 3'b000;
  localparam logic [2:0] OP_MSUB   = 3'b001;
  localparam logic [2:0] OP_MEMUL  = 3'b010;
  localparam logic [2:0] OP_MATMUL = 3'b011;
  localparam logic [2:0] OP_MTRANS = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [RW-1:0] row;
  logic [DW-1:0] a_q, b_q;
  logic [DW-1:0] result_q;
  logic [4:0]    res_rd_q;
  logic [DW-1:0] ew_res;
  logic [ROW_W-1:0] mm_row;
  logic signed [AW-1:0] acc;
  logic          accept;

  // Element (r,c) of a packed matrix as a signed value.
  function automatic logic signed [ELEM_W-1:0] elem(input logic [DW-1:0] m,
                                                    input int r, input int c);
    return signed'(m[(r*DIM+c)*ELEM_W +: ELEM_W]);
  endfunction

  // Reduce a full-precision value to one output element.
  function automatic logic [ELEM_W-1:0] fit(input logic signed [AW-1:0] v);
`ifdef MATRIX_SAT_EN
    logic signed [AW-1:0] sat_max;
    logic signed [AW-1:0] sat_min;
    sat_max = AW'((1 << (ELEM_W-1)) - 1);
    sat_min = -sat_max - AW'(1);
    if (v > sat_max)      return sat_max[ELEM_W-1:0];
    else if (v < sat_min) return sat_min[ELEM_W-1:0];
    else                  return v[ELEM_W-1:0];
`else
    return v[ELEM_W-1:0];
`endif
  endfunction

  assign accept = (state == IDLE) && bus.start && !bus.flush;

  // Element-wise/transpose result straight from the incoming operands.
  always_comb begin
    ew_res = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        case (bus.func3)
          OP_MADD:   ew_res[(r*DIM+c)*ELEM_W +: ELEM_W] =
                       fit(AW'(elem(bus.a_data, r, c)) + AW'(elem(bus.b_data, r, c)));
          OP_MSUB:   ew_res[(r*DIM+c)*ELEM_W +: ELEM_W] =
                       fit(AW'(elem(bus.a_data, r, c)) - AW'(elem(bus.b_data, r, c)));
          OP_MEMUL:  ew_res[(r*DIM+c)*ELEM_W +: ELEM_W] =
                       fit(AW'(elem(bus.a_data, r, c)) * AW'(elem(bus.b_data, r, c)));
          OP_MTRANS: ew_res[(r*DIM+c)*ELEM_W +: ELEM_W] = elem(bus.a_data, c, r);
          default:   ;
        endcase
      end
    end
  end

  // One MATMUL result row (index row) from the latched operands.
  always_comb begin
    mm_row = '0;
    acc    = '0;
    for (int c = 0; c < DIM; c++) begin
      acc = '0;
      for (int k = 0; k < DIM; k++) begin
        acc = acc + AW'(elem(a_q, int'(row), k)) * AW'(elem(b_q, k, c));
      end
      mm_row[c*ELEM_W +: ELEM_W] = fit(acc);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next-state and control outputs.
  always_comb begin
    state_d       = state;
    bus.stall     = 1'b0;
    bus.busy      = (state != IDLE);
    bus.done      = (state == DONE);
    bus.state_dbg = state;
    case (state)
      IDLE: begin
        bus.stall = bus.start;
        if (accept) state_d = (bus.func3 == OP_MATMUL) ? CALC : DONE;
      end
      CALC: begin
        bus.stall = 1'b1;
        if (row == RW'(DIM - 1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  // Operand latch, row counter, result and destination tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      res_rd_q <= '0;
    end else if (bus.flush) begin
      row      <= '0;
      result_q <= '0;
      res_rd_q <= '0;
    end else if (accept) begin
      a_q      <= bus.a_data;
      b_q      <= bus.b_data;
      res_rd_q <= bus.rd_in;
      row      <= '0;
      if (bus.func3 != OP_MATMUL) result_q <= ew_res;
    end else if (state == CALC) begin
      result_q[int'(row)*ROW_W +: ROW_W] <= mm_row;
      row <= row + RW'(1);
    end
  end

  assign bus.result = result_q;
  assign bus.res_rd = res_rd_q;
endmodule

// File: tb/tb_ex_matrix_unit.sv
// Directed bench for ex_matrix_unit: hand-computed vectors for each op,
// latency/stall timing, flush and reset aborts during MATMUL.
module tb_ex_matrix_unit;
  localparam int DW = 128;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ex_matrix_if #(.ELEM_W(8), .DIM(4)) bus ();

  ex_matrix_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [DW-1:0] IDENT = 128'h01000000_00010000_00000100_00000001;
  localparam logic [DW-1:0] SEQ   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [DW-1:0] TR_A  = 128'h00000000_00000000_00000022_00001100;
  localparam logic [DW-1:0] TR_R  = 128'h00000000_00000000_00000011_00002200;

`ifdef MATRIX_SAT_EN
  localparam logic [DW-1:0] MM_BIG_EXP = {16{8'h7f}};
  localparam logic [DW-1:0] MSUB_EXP   = {16{8'h80}};
`else
  localparam logic [DW-1:0] MM_BIG_EXP = '0;
  localparam logic [DW-1:0] MSUB_EXP   = {16{8'h7f}};
`endif

  // Scoreboard check
  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs may be changed right after.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Driver: present one instruction (start held for the current cycle).
  task automatic issue(input logic [2:0] f3, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [4:0] rd);
    bus.start  = 1'b1;
    bus.func3  = f3;
    bus.a_data = a;
    bus.b_data = b;
    bus.rd_in  = rd;
    #1;
  endtask

  // Run a MATMUL to completion checking stall/done per cycle.
  task automatic run_matmul(input string tag, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [DW-1:0] exp);
    issue(3'b011, a, b, 5'd3);
    chk({tag, "_stall_c0"}, DW'(bus.stall), DW'(1));
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk($sformatf("%s_stall_c%0d", tag, c), DW'({bus.stall, bus.done}), DW'(2'b10));
      tick();
    end
    #1;
    chk({tag, "_done_c5"}, DW'({bus.stall, bus.done}), DW'(2'b01));
    chk({tag, "_result"}, bus.result, exp);
    tick();
  endtask

  initial begin
    rst        = 1'b0;
    bus.flush  = 1'b0;
    bus.start  = 1'b0;
    bus.func3  = 3'b000;
    bus.a_data = '0;
    bus.b_data = '0;
    bus.rd_in  = '0;
    tick();
    tick();
    chk("rst_busy",   DW'(bus.busy), DW'(0));
    chk("rst_done",   DW'(bus.done), DW'(0));
    chk("rst_stall",  DW'(bus.stall), DW'(0));
    chk("rst_result", bus.result, '0);
    chk("rst_res_rd", DW'(bus.res_rd), DW'(0));
    rst = 1'b1;
    tick();

    // MADD 5+3
    issue(3'b000, {16{8'h05}}, {16{8'h03}}, 5'd7);
    chk("madd_stall_c0", DW'(bus.stall), DW'(1));
    chk("madd_done_c0",  DW'(bus.done), DW'(0));
    tick();
    bus.start = 1'b0;
    #1;
    chk("madd_done_c1",  DW'(bus.done), DW'(1));
    chk("madd_stall_c1", DW'(bus.stall), DW'(0));
    chk("madd_result",   bus.result, {16{8'h08}});
    chk("madd_res_rd",   DW'(bus.res_rd), DW'(7));
    tick();
    chk("madd_done_c2",  DW'(bus.done), DW'(0));
    chk("madd_busy_c2",  DW'(bus.busy), DW'(0));
    chk("madd_hold",     bus.result, {16{8'h08}});

    // MATMUL identity * SEQ
    run_matmul("mm_ident", IDENT, SEQ, SEQ);
    chk("mm_ident_res_rd", DW'(bus.res_rd), DW'(3));

    // MATMUL large values
    run_matmul("mm_big", {16{8'h10}}, {16{8'h10}}, MM_BIG_EXP);

    // MSUB 0x80 - 0x01
    issue(3'b001, {16{8'h80}}, {16{8'h01}}, 5'd9);
    tick();
    bus.start = 1'b0;
    #1;
    chk("msub_done",   DW'(bus.done), DW'(1));
    chk("msub_result", bus.result, MSUB_EXP);
    tick();

    // MEMUL 3 * -2
    issue(3'b010, {16{8'h03}}, {16{8'hfe}}, 5'd4);
    tick();
    bus.start = 1'b0;
    #1;
    chk("memul_result", bus.result, {16{8'hfa}});
    tick();

    // Prime a nonzero result, then flush a MATMUL at cycle 2
    run_matmul("mm_pre", IDENT, SEQ, SEQ);
    issue(3'b011, IDENT, SEQ, 5'd12);
    tick();
    bus.start = 1'b0;
    tick();
    bus.flush = 1'b1;
    #1;
    chk("flush_stall_c2", DW'(bus.stall), DW'(1));
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush_busy",   DW'(bus.busy), DW'(0));
    chk("flush_stall",  DW'(bus.stall), DW'(0));
    chk("flush_result", bus.result, '0);
    chk("flush_res_rd", DW'(bus.res_rd), DW'(0));
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("flush_nodone_%0d", c), DW'(bus.done), DW'(0));
      tick();
    end

    // Same abort via reset
    run_matmul("mm_pre2", IDENT, SEQ, SEQ);
    issue(3'b011, IDENT, SEQ, 5'd13);
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rstab_busy",   DW'(bus.busy), DW'(0));
    chk("rstab_stall",  DW'(bus.stall), DW'(0));
    chk("rstab_result", bus.result, '0);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("rstab_nodone_%0d", c), DW'(bus.done), DW'(0));
      tick();
    end

    // Flush in the accept cycle blocks the accept
    issue(3'b000, {16{8'h01}}, {16{8'h01}}, 5'd5);
    bus.flush = 1'b1;
    #1;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    chk("flush_acc_busy", DW'(bus.busy), DW'(0));
    chk("flush_acc_done", DW'(bus.done), DW'(0));
    chk("flush_acc_res",  bus.result, '0);
    tick();

    // MTRANS
    issue(3'b100, TR_A, {16{8'hff}}, 5'd2);
    tick();
    bus.start = 1'b0;
    #1;
    chk("mtrans_done",   DW'(bus.done), DW'(1));
    chk("mtrans_result", bus.result, TR_R);
    tick();

    // Reserved op
    issue(3'b111, {16{8'h05}}, {16{8'h03}}, 5'd31);
    tick();
    bus.start = 1'b0;
    #1;
    chk("rsvd_done",   DW'(bus.done), DW'(1));
    chk("rsvd_result", bus.result, '0);
    chk("rsvd_res_rd", DW'(bus.res_rd), DW'(31));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
